// File: rtl/gate_control_scheduler.sv
// gate_control_scheduler
//   Walks one port's gate control list (GCL) once per scheduling cycle. Each
//   list entry holds a gate vector and an interval in clock cycles. The entry
//   after the current one is read ahead of time from the external GCL RAM.
//   This lets every gate change land on an exact clock boundary.
//
// State table
//   state        | meaning
//   S_IDLE       | not scheduling; gates forced open
//   S_FIRST_RD   | read of entry 0 on the RAM port
//   S_FIRST_WAIT | entry 0 data on rdata; apply it, prefetch entry 1
//   S_RUN        | entry applied, interval counter running down
//   S_HOLD       | list finished; last gate vector held until next start
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_gate_enable     0 forces gates open and ignores cycle starts
//   iv_entry_num      list length, sampled on an accepted cycle start
//   i_cycle_start     one-cycle pulse starting a scheduling cycle
//   o_gcl_rd          RAM read strobe
//   ov_gcl_raddr      RAM read address
//   iv_gcl_rdata      RAM data {gate_state, interval}, 1 cycle after o_gcl_rd
//   ov_gate_state     current gate vector (1 = open)
//   ov_entry_index    index of the applied entry
//   o_list_done       pulse in the first HOLD cycle
//   o_cycle_overrun   pulse when a start aborts an unfinished list
module gate_control_scheduler #(
  parameter int GATE_NUM       = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int INTERVAL_WIDTH = 24
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_gate_enable,
  input  logic [ADDR_WIDTH:0]                iv_entry_num,
  input  logic                               i_cycle_start,
  output logic                               o_gcl_rd,
  output logic [ADDR_WIDTH-1:0]              ov_gcl_raddr,
  input  logic [GATE_NUM+INTERVAL_WIDTH-1:0] iv_gcl_rdata,
  output logic [GATE_NUM-1:0]                ov_gate_state,
  output logic [ADDR_WIDTH-1:0]              ov_entry_index,
  output logic                               o_list_done,
  output logic                               o_cycle_overrun
);

  localparam int DW = GATE_NUM + INTERVAL_WIDTH;
  localparam int NW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST_RD, S_FIRST_WAIT, S_RUN, S_HOLD
  } state_t;

  state_t                    state_q, state_n;
  logic [GATE_NUM-1:0]       gate_q, gate_n;
  logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_n;
  logic [ADDR_WIDTH-1:0]     raddr_q, raddr_n;
  logic [NW-1:0]             num_q, num_n;
  logic [DW-1:0]             shadow_q, shadow_n;
  logic                      shadow_vld_q, shadow_vld_n;
  logic                      rd_q, rd_n;
  logic                      rvalid_q, rvalid_n;
  logic                      done_q, done_n;
  logic                      ovr_q, ovr_n;

  logic                      start_acc, start_zero;
  logic                      expire, is_last;
  logic [NW-1:0]             idx_ext;
  logic [DW-1:0]             apply_data;

  // Intervals below 2 leave no room for the prefetch, so they are clamped to 2.
  function automatic logic [INTERVAL_WIDTH-1:0] load_cnt(input logic [DW-1:0] e);
    logic [INTERVAL_WIDTH-1:0] iv;
    iv = e[INTERVAL_WIDTH-1:0];
    return (iv[INTERVAL_WIDTH-1:1] == '0) ? INTERVAL_WIDTH'(2) : iv;
  endfunction

  assign start_acc  = i_cycle_start && i_gate_enable && (iv_entry_num != '0);
  assign start_zero = i_cycle_start && i_gate_enable && (iv_entry_num == '0);
  assign idx_ext    = {1'b0, idx_q};
  assign is_last    = (idx_ext + NW'(1)) == num_q;
  assign expire     = (state_q == S_RUN) && (cnt_q == INTERVAL_WIDTH'(1));
  // Data arriving on the expiry cycle bypasses the shadow register.
  assign apply_data = rvalid_q ? iv_gcl_rdata : shadow_q;

  always_comb begin
    state_n      = state_q;
    gate_n       = gate_q;
    cnt_n        = cnt_q;
    idx_n        = idx_q;
    raddr_n      = raddr_q;
    num_n        = num_q;
    shadow_n     = shadow_q;
    shadow_vld_n = shadow_vld_q;
    rd_n         = 1'b0;
    rvalid_n     = rd_q;
    done_n       = 1'b0;
    ovr_n        = 1'b0;

    if (!i_gate_enable) begin
      state_n      = S_IDLE;
      gate_n       = '1;
      idx_n        = '0;
      shadow_vld_n = 1'b0;
      rvalid_n     = 1'b0;
    end else begin
      case (state_q)
        S_FIRST_RD: state_n = S_FIRST_WAIT;
        S_FIRST_WAIT: begin
          gate_n       = iv_gcl_rdata[DW-1:INTERVAL_WIDTH];
          cnt_n        = load_cnt(iv_gcl_rdata);
          idx_n        = '0;
          shadow_vld_n = 1'b0;
          state_n      = S_RUN;
          if (num_q > NW'(1)) begin
            rd_n    = 1'b1;
            raddr_n = ADDR_WIDTH'(1);
          end
        end
        S_RUN: begin
          cnt_n = cnt_q - INTERVAL_WIDTH'(1);
          if (expire) begin
            if (is_last) begin
              state_n = S_HOLD;
              done_n  = 1'b1;
            end else begin
              gate_n       = apply_data[DW-1:INTERVAL_WIDTH];
              cnt_n        = load_cnt(apply_data);
              idx_n        = idx_q + ADDR_WIDTH'(1);
              shadow_vld_n = 1'b0;
              if ((idx_ext + NW'(2)) < num_q) begin
                rd_n    = 1'b1;
                raddr_n = idx_q + ADDR_WIDTH'(2);
              end
            end
          end else if (rvalid_q) begin
            shadow_n     = iv_gcl_rdata;
            shadow_vld_n = 1'b1;
          end
        end
        default: ;
      endcase

      if (start_zero) begin
        state_n      = S_IDLE;
        gate_n       = '1;
        idx_n        = '0;
        shadow_vld_n = 1'b0;
        rd_n         = 1'b0;
      end else if (start_acc) begin
        // A start on the last entry's expiry counts as a clean finish.
        ovr_n        = (state_q inside {S_FIRST_RD, S_FIRST_WAIT, S_RUN}) &&
                       !(expire && is_last);
        state_n      = S_FIRST_RD;
        gate_n       = gate_q;
        idx_n        = idx_q;
        rd_n         = 1'b1;
        raddr_n      = '0;
        num_n        = iv_entry_num;
        shadow_vld_n = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      gate_q       <= '1;
      cnt_q        <= '0;
      idx_q        <= '0;
      raddr_q      <= '0;
      num_q        <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      rd_q         <= 1'b0;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      gate_q       <= gate_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      raddr_q      <= raddr_n;
      num_q        <= num_n;
      shadow_q     <= shadow_n;
      shadow_vld_q <= shadow_vld_n;
      rd_q         <= rd_n;
      rvalid_q     <= rvalid_n;
      done_q       <= done_n;
      ovr_q        <= ovr_n;
    end
  end

  assign o_gcl_rd        = rd_q;
  assign ov_gcl_raddr    = raddr_q;
  assign ov_gate_state   = gate_q;
  assign ov_entry_index  = idx_q;
  assign o_list_done     = done_q;
  assign o_cycle_overrun = ovr_q;

endmodule

// File: tb/tb_gate_control_scheduler.sv
module tb_gate_control_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_gate_enable;
  logic [5:0]  iv_entry_num;
  logic        i_cycle_start;
  logic        o_gcl_rd;
  logic [4:0]  ov_gcl_raddr;
  logic [31:0] iv_gcl_rdata;
  logic [7:0]  ov_gate_state;
  logic [4:0]  ov_entry_index;
  logic        o_list_done;
  logic        o_cycle_overrun;

  logic [31:0] mem [0:31];
  int checks = 0;
  int errors = 0;

  gate_control_scheduler dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_gate_enable   (i_gate_enable),
    .iv_entry_num    (iv_entry_num),
    .i_cycle_start   (i_cycle_start),
    .o_gcl_rd        (o_gcl_rd),
    .ov_gcl_raddr    (ov_gcl_raddr),
    .iv_gcl_rdata    (iv_gcl_rdata),
    .ov_gate_state   (ov_gate_state),
    .ov_entry_index  (ov_entry_index),
    .o_list_done     (o_list_done),
    .o_cycle_overrun (o_cycle_overrun)
  );

  always #5 i_clk = ~i_clk;

  // GCL RAM with one cycle read latency
  always @(posedge i_clk) begin
    if (o_gcl_rd) iv_gcl_rdata <= mem[ov_gcl_raddr];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_list_a();
    mem[0] = {8'h01, 24'd5};
    mem[1] = {8'h02, 24'd3};
    mem[2] = {8'h80, 24'd4};
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    iv_gcl_rdata  = 32'h0;
    load_list_a();
    i_rst         = 1'b1;
    i_gate_enable = 1'b1;
    iv_entry_num  = 6'd0;
    i_cycle_start = 1'b0;
    step(3);
    check("rst_gate", ov_gate_state, 8'hFF);
    check("rst_rd", o_gcl_rd, 1'b0);
    check("rst_raddr", ov_gcl_raddr, 5'd0);
    check("rst_idx", ov_entry_index, 5'd0);
    check("rst_done", o_list_done, 1'b0);
    check("rst_ovr", o_cycle_overrun, 1'b0);
    i_rst = 1'b0;
    step(1);

    // basic list, entry_num changed mid-list must not matter
    iv_entry_num = 6'd3; i_cycle_start = 1'b1;
    step(1);                                   // T+1
    i_cycle_start = 1'b0; iv_entry_num = 6'd1;
    check("t1_rd0", o_gcl_rd, 1'b1);
    check("t1_raddr0", ov_gcl_raddr, 5'd0);
    check("t1_gate_t1", ov_gate_state, 8'hFF);
    step(1);                                   // T+2
    check("t1_rd_t2", o_gcl_rd, 1'b0);
    check("t1_gate_t2", ov_gate_state, 8'hFF);
    step(1);                                   // T+3
    check("t1_gate_t3", ov_gate_state, 8'h01);
    check("t1_idx_t3", ov_entry_index, 5'd0);
    check("t1_rd_t3", o_gcl_rd, 1'b1);
    check("t1_raddr_t3", ov_gcl_raddr, 5'd1);
    step(4);                                   // T+7
    check("t1_gate_t7", ov_gate_state, 8'h01);
    step(1);                                   // T+8
    check("t1_gate_t8", ov_gate_state, 8'h02);
    check("t1_idx_t8", ov_entry_index, 5'd1);
    check("t1_rd_t8", o_gcl_rd, 1'b1);
    check("t1_raddr_t8", ov_gcl_raddr, 5'd2);
    step(2);                                   // T+10
    check("t1_gate_t10", ov_gate_state, 8'h02);
    step(1);                                   // T+11
    check("t1_gate_t11", ov_gate_state, 8'h80);
    check("t1_idx_t11", ov_entry_index, 5'd2);
    check("t1_rd_t11", o_gcl_rd, 1'b0);
    step(3);                                   // T+14
    check("t1_done_t14", o_list_done, 1'b0);
    check("t1_gate_t14", ov_gate_state, 8'h80);
    step(1);                                   // T+15
    check("t1_done_t15", o_list_done, 1'b1);
    check("t1_ovr_t15", o_cycle_overrun, 1'b0);
    step(1);                                   // T+16
    check("t1_done_t16", o_list_done, 1'b0);
    step(2);
    check("t1_hold", ov_gate_state, 8'h80);

    // intervals 0 and 1 clamp to 2; start from HOLD raises no overrun
    mem[0] = {8'h11, 24'd0};
    mem[1] = {8'h22, 24'd1};
    mem[2] = {8'h44, 24'd3};
    iv_entry_num = 6'd3; i_cycle_start = 1'b1;
    step(1);                                   // S+1
    i_cycle_start = 1'b0;
    check("t2_ovr", o_cycle_overrun, 1'b0);
    check("t2_rd_s1", o_gcl_rd, 1'b1);
    check("t2_gate_s1", ov_gate_state, 8'h80);
    step(2);                                   // S+3
    check("t2_gate_s3", ov_gate_state, 8'h11);
    check("t2_rd_s3", o_gcl_rd, 1'b1);
    check("t2_raddr_s3", ov_gcl_raddr, 5'd1);
    step(1);                                   // S+4
    check("t2_gate_s4", ov_gate_state, 8'h11);
    check("t2_rd_s4", o_gcl_rd, 1'b0);
    step(1);                                   // S+5
    check("t2_gate_s5", ov_gate_state, 8'h22);
    check("t2_idx_s5", ov_entry_index, 5'd1);
    check("t2_rd_s5", o_gcl_rd, 1'b1);
    check("t2_raddr_s5", ov_gcl_raddr, 5'd2);
    step(1);                                   // S+6
    check("t2_gate_s6", ov_gate_state, 8'h22);
    check("t2_rd_s6", o_gcl_rd, 1'b0);
    step(1);                                   // S+7
    check("t2_gate_s7", ov_gate_state, 8'h44);
    check("t2_rd_s7", o_gcl_rd, 1'b0);
    step(2);                                   // S+9
    check("t2_done_s9", o_list_done, 1'b0);
    step(1);                                   // S+10
    check("t2_done_s10", o_list_done, 1'b1);

    // abort while entry 1 is active
    load_list_a();
    step(1);
    i_cycle_start = 1'b1;
    step(1);                                   // A+1
    i_cycle_start = 1'b0;
    step(7);                                   // A+8
    check("t3_gate_a8", ov_gate_state, 8'h02);
    step(1);                                   // A+9 = X
    i_cycle_start = 1'b1;
    step(1);                                   // X+1
    i_cycle_start = 1'b0;
    check("t3_ovr_x1", o_cycle_overrun, 1'b1);
    check("t3_gate_x1", ov_gate_state, 8'h02);
    check("t3_rd_x1", o_gcl_rd, 1'b1);
    check("t3_raddr_x1", ov_gcl_raddr, 5'd0);
    step(1);                                   // X+2
    check("t3_ovr_x2", o_cycle_overrun, 1'b0);
    check("t3_gate_x2", ov_gate_state, 8'h02);
    step(1);                                   // X+3
    check("t3_gate_x3", ov_gate_state, 8'h01);
    check("t3_idx_x3", ov_entry_index, 5'd0);

    // start on the last entry's expiry cycle
    step(11);                                  // X+14 = Y
    check("t4_gate_y", ov_gate_state, 8'h80);
    check("t4_done_y", o_list_done, 1'b0);
    i_cycle_start = 1'b1;
    step(1);                                   // Y+1
    i_cycle_start = 1'b0;
    check("t4_done_y1", o_list_done, 1'b1);
    check("t4_ovr_y1", o_cycle_overrun, 1'b0);
    check("t4_gate_y1", ov_gate_state, 8'h80);
    check("t4_rd_y1", o_gcl_rd, 1'b1);
    step(2);                                   // Y+3
    check("t4_gate_y3", ov_gate_state, 8'h01);
    check("t4_idx_y3", ov_entry_index, 5'd0);

    // entry_num = 0 start mid-list
    step(1);                                   // Y+4
    iv_entry_num = 6'd0; i_cycle_start = 1'b1;
    step(1);
    i_cycle_start = 1'b0;
    check("t5_gate_zero", ov_gate_state, 8'hFF);
    check("t5_rd_zero", o_gcl_rd, 1'b0);
    check("t5_ovr_zero", o_cycle_overrun, 1'b0);
    step(1);
    check("t5_rd_zero2", o_gcl_rd, 1'b0);
    check("t5_gate_zero2", ov_gate_state, 8'hFF);

    // disable mid-list, starts ignored while disabled
    iv_entry_num = 6'd3; i_cycle_start = 1'b1;
    step(1);
    i_cycle_start = 1'b0;
    step(7);
    check("t5_gate_run", ov_gate_state, 8'h02);
    i_gate_enable = 1'b0;
    step(1);
    check("t5_gate_dis", ov_gate_state, 8'hFF);
    check("t5_rd_dis", o_gcl_rd, 1'b0);
    i_cycle_start = 1'b1;
    step(1);
    i_cycle_start = 1'b0;
    check("t5_rd_dis_start", o_gcl_rd, 1'b0);
    step(2);
    check("t5_rd_dis_late", o_gcl_rd, 1'b0);
    check("t5_gate_dis_late", ov_gate_state, 8'hFF);
    i_gate_enable = 1'b1;
    step(2);
    check("t5_rd_reen", o_gcl_rd, 1'b0);

    // reset during RUN
    i_cycle_start = 1'b1;
    step(1);                                   // Z+1
    i_cycle_start = 1'b0;
    step(4);                                   // Z+5
    check("t6_gate_run", ov_gate_state, 8'h01);
    i_rst = 1'b1;
    step(1);                                   // Z+6
    i_rst = 1'b0;
    check("t6_gate_rst", ov_gate_state, 8'hFF);
    check("t6_idx_rst", ov_entry_index, 5'd0);
    check("t6_rd_rst", o_gcl_rd, 1'b0);
    step(3);
    check("t6_rd_after", o_gcl_rd, 1'b0);
    check("t6_gate_after", ov_gate_state, 8'hFF);
    i_cycle_start = 1'b1;
    step(1);
    i_cycle_start = 1'b0;
    step(2);
    check("t6_gate_restart", ov_gate_state, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
